// File: rtl/tx_gearbox_pkg.sv
// Shared 64b/66b core constants: block geometry, sync headers and gearbox buffer sizing.
package tx_gearbox_pkg;

    localparam int GB_BLOCK_WIDTH = 66;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // Worst case: up to 2*OUT_WIDTH-2 leftover bits plus one freshly appended block.
    function automatic int buf_width(input int block_w, input int out_w);
        return block_w + 2 * out_w - 2;
    endfunction

endpackage

// File: rtl/tx_gearbox.sv
// 66b block -> OUT_WIDTH word gearbox; first bit of a block reaches out_data 2 edges after it is accepted into an empty buffer.
// in_ready depends only on registered occupancy (never on in_valid); an empty buffer emits zeros and counts underruns.
module tx_gearbox
    import tx_gearbox_pkg::*;
#(
    parameter int BLOCK_WIDTH = GB_BLOCK_WIDTH,
    parameter int OUT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BLOCK_WIDTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_valid,
    output logic [15:0]            underrun_cnt,
    output logic [7:0]             fill
);

    localparam int         BUF_W     = buf_width(BLOCK_WIDTH, OUT_WIDTH);
    localparam logic [7:0] OW        = 8'(OUT_WIDTH);
    localparam logic [7:0] BW        = 8'(BLOCK_WIDTH);
    localparam logic [7:0] READY_MAX = 8'(2 * OUT_WIDTH - 2);

    logic [BUF_W-1:0]     r_buf;
    logic [7:0]           r_cnt;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic                 r_out_valid;
    logic [15:0]          r_underrun;
    logic                 r_emitted;

    logic                 w_emit;
    logic [7:0]           w_rem;
    logic [BUF_W-1:0]     w_kept;
    logic                 w_accept;

    // Bits below the occupancy are always zero, so OR-ing in the aligned block is enough.
    function automatic logic [BUF_W-1:0] insert_block(
        input logic [BUF_W-1:0]       kept,
        input logic [BLOCK_WIDTH-1:0] blk,
        input logic [7:0]             rem
    );
        logic [BUF_W-1:0] aligned;
        aligned = {blk, {(BUF_W - BLOCK_WIDTH){1'b0}}};
        return kept | (aligned >> rem);
    endfunction

    assign w_emit   = (r_cnt >= OW);
    assign w_rem    = w_emit ? (r_cnt - OW) : r_cnt;
    assign w_kept   = w_emit ? (r_buf << OUT_WIDTH) : r_buf;
    assign in_ready = !rst_n || (w_rem <= READY_MAX);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_underrun  <= '0;
            r_emitted   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf <= insert_block(w_kept, in_data, w_rem);
                r_cnt <= w_rem + BW;
            end else begin
                r_buf <= w_kept;
                r_cnt <= w_rem;
            end

            if (w_emit) begin
                r_out_data  <= r_buf[BUF_W-1 -: OUT_WIDTH];
                r_out_valid <= 1'b1;
                r_emitted   <= 1'b1;
            end else begin
                r_out_data  <= '0;
                r_out_valid <= 1'b0;
                // Startup idle before the first word is not an underrun.
                if (r_emitted && (r_underrun != 16'hFFFF)) begin
                    r_underrun <= r_underrun + 16'd1;
                end
            end
        end
    end

    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign underrun_cnt = r_underrun;
    assign fill         = r_cnt;

endmodule
